oc8051_pt_loader: RTL and testbench

Sequencer that initialises the 8051 page-table permission registers from a 64-byte image held in memory. It also arbitrates the page-table register port between the CPU and itself.
- On `start`, it reads image bytes 0..63 from a source bus and writes each one, with privilege asserted, to page-table address PT_BASE+i.
- Bytes 0..31 land in the write-enable bank (ff80..ff9f); bytes 32..63 land in the read-enable bank (ffa0..ffbf).
- The CPU reaches the page table through this block. It is passed through when the loader is idle and stalled while a load is in progress.

---
 rtl/oc8051_pt_loader_pkg.sv | 22 ++
 rtl/oc8051_pt_bus_mux.sv | 41 ++++
 rtl/oc8051_pt_loader.sv | 213 +++++++++++++++++++++
 tb/tb_oc8051_pt_loader.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/oc8051_pt_loader_pkg.sv
// Shared types and constants for the 8051 page-table loader.
// State encoding, page-table bank bases and a small bank helper.
package oc8051_pt_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_GRANT  = 3'd1,
    ST_READ   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_VERIFY = 3'd4,
    ST_DONE   = 3'd5
  } ld_state_e;

  localparam logic [15:0] PT_WR_BASE = 16'hff80;
  localparam logic [15:0] PT_RD_BASE = 16'hffa0;

  // True when an address falls in the read-enable bank (ffa0..ffbf).
  function automatic logic pt_in_rd_bank(input logic [15:0] addr);
    return (addr >= PT_RD_BASE) && (addr < (PT_RD_BASE + 16'd32));
  endfunction

endpackage

// File: rtl/oc8051_pt_bus_mux.sv
// Page-table port select between the CPU and the loader.
// cpu_sel routes the CPU onto pt_*; cpu_ack_en lets the page-table ack reach the CPU.
module oc8051_pt_bus_mux (
  input  logic        cpu_sel,
  input  logic        cpu_ack_en,
  input  logic        cpu_stb,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_priv,
  input  logic        ld_stb,
  input  logic        ld_wr,
  input  logic [15:0] ld_addr,
  input  logic [7:0]  ld_wdata,
  input  logic        ld_priv,
  input  logic        pt_ack,
  output logic        cpu_ack,
  output logic        pt_stb,
  output logic        pt_wr,
  output logic [15:0] pt_addr,
  output logic [7:0]  pt_wdata,
  output logic        pt_priv
);

  always_comb begin
    pt_stb   = ld_stb;
    pt_wr    = ld_wr;
    pt_addr  = ld_addr;
    pt_wdata = ld_wdata;
    pt_priv  = ld_priv;
    if (cpu_sel) begin
      pt_stb   = cpu_stb;
      pt_wr    = cpu_wr;
      pt_addr  = cpu_addr;
      pt_wdata = cpu_data;
      pt_priv  = cpu_priv;
    end
    cpu_ack = cpu_ack_en & pt_ack;
  end

endmodule

// File: rtl/oc8051_pt_loader.sv
// Loads the page-table permission image from a source bus and arbitrates the page-table port.
// Optional readback check after each write: define OC8051_PT_LOADER_VERIFY_EN.
//
// state  | meaning
// IDLE   | CPU owns the page table; waiting for start
// GRANT  | let an in-flight CPU transfer finish before taking the port
// READ   | fetch image byte idx from the source bus
// WRITE  | privileged write of the captured byte to PT_BASE+idx
// VERIFY | privileged readback of PT_BASE+idx (optional build)
// DONE   | one-cycle done pulse, then back to IDLE
module oc8051_pt_loader
  import oc8051_pt_loader_pkg::*;
#(
  parameter logic [15:0] PT_BASE  = PT_WR_BASE,
  parameter int          PT_BYTES = 64,
  parameter int          TMO_CYC  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] img_base,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        src_stb,
  output logic [15:0] src_addr,
  input  logic [7:0]  src_data,
  input  logic        src_ack,
  input  logic        cpu_stb,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data,
  input  logic        cpu_priv,
  output logic        cpu_ack,
  output logic        pt_stb,
  output logic        pt_wr,
  output logic [15:0] pt_addr,
  output logic [7:0]  pt_wdata,
  output logic        pt_priv,
  input  logic [7:0]  pt_rdata,
  input  logic        pt_ack
);

  localparam int IW = (PT_BYTES > 1) ? $clog2(PT_BYTES) : 1;
  localparam int TW = $clog2(TMO_CYC + 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(PT_BYTES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);

  ld_state_e   state, state_nxt;
  logic [15:0] img_base_q;
  logic [IW-1:0] idx;
  logic [7:0]  byte_q;
  logic [TW-1:0] tmo_cnt;

  logic        accept, cap_byte, idx_inc, advance, abort, set_err, waiting;
  logic        cpu_sel, cpu_ack_en;
  logic        ld_stb, ld_wr, ld_priv;
  logic [15:0] ld_addr;
  logic        tmo_hit;

  assign tmo_hit = (tmo_cnt == TMO_LAST);
  assign ld_addr = PT_BASE + 16'(idx);
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);

`ifndef OC8051_PT_LOADER_VERIFY_EN
  // Readback data is only consumed by the verify build.
  logic unused_rdata;
  assign unused_rdata = ^pt_rdata;
`endif

  always_comb begin
    state_nxt  = state;
    accept     = 1'b0;
    cap_byte   = 1'b0;
    idx_inc    = 1'b0;
    advance    = 1'b0;
    abort      = 1'b0;
    set_err    = 1'b0;
    waiting    = 1'b0;
    cpu_sel    = 1'b0;
    cpu_ack_en = 1'b0;
    ld_stb     = 1'b0;
    ld_wr      = 1'b0;
    ld_priv    = 1'b0;
    src_stb    = 1'b0;
    src_addr   = 16'h0000;

    case (state)
      ST_IDLE: begin
        cpu_sel    = 1'b1;
        cpu_ack_en = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        // The CPU keeps the port only for the transfer already on the bus.
        cpu_sel = 1'b1;
        if (cpu_stb) begin
          waiting = 1'b1;
          if (pt_ack)       state_nxt = ST_READ;
          else if (tmo_hit) abort     = 1'b1;
        end else begin
          state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        src_stb  = 1'b1;
        src_addr = img_base_q + 16'(idx);
        waiting  = 1'b1;
        if (src_ack) begin
          cap_byte  = 1'b1;
          state_nxt = ST_WRITE;
        end else if (tmo_hit) begin
          abort = 1'b1;
        end
      end
      ST_WRITE: begin
        ld_stb  = 1'b1;
        ld_wr   = 1'b1;
        ld_priv = 1'b1;
        waiting = 1'b1;
        if (pt_ack) begin
`ifdef OC8051_PT_LOADER_VERIFY_EN
          state_nxt = ST_VERIFY;
`else
          advance = 1'b1;
`endif
        end else if (tmo_hit) begin
          abort = 1'b1;
        end
      end
`ifdef OC8051_PT_LOADER_VERIFY_EN
      ST_VERIFY: begin
        ld_stb  = 1'b1;
        ld_priv = 1'b1;
        waiting = 1'b1;
        if (pt_ack) begin
          if (pt_rdata != byte_q) begin
            set_err   = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            advance = 1'b1;
          end
        end else if (tmo_hit) begin
          abort = 1'b1;
        end
      end
`endif
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase

    if (advance) begin
      if (idx == IDX_LAST) begin
        state_nxt = ST_DONE;
      end else begin
        idx_inc   = 1'b1;
        state_nxt = ST_READ;
      end
    end
    if (abort) state_nxt = ST_DONE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      img_base_q <= 16'h0000;
      idx        <= '0;
      byte_q     <= 8'h00;
      err        <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        img_base_q <= img_base;
        idx        <= '0;
        err        <= 1'b0;
      end
      if (idx_inc)           idx    <= idx + 1'b1;
      if (cap_byte)          byte_q <= src_data;
      if (abort || set_err)  err    <= 1'b1;
      // Each new wait starts its own timeout window.
      if (state_nxt != state) tmo_cnt <= '0;
      else if (waiting)       tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  oc8051_pt_bus_mux u_mux (
    .cpu_sel    (cpu_sel),
    .cpu_ack_en (cpu_ack_en),
    .cpu_stb    (cpu_stb),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .cpu_data   (cpu_data),
    .cpu_priv   (cpu_priv),
    .ld_stb     (ld_stb),
    .ld_wr      (ld_wr),
    .ld_addr    (ld_addr),
    .ld_wdata   (byte_q),
    .ld_priv    (ld_priv),
    .pt_ack     (pt_ack),
    .cpu_ack    (cpu_ack),
    .pt_stb     (pt_stb),
    .pt_wr      (pt_wr),
    .pt_addr    (pt_addr),
    .pt_wdata   (pt_wdata),
    .pt_priv    (pt_priv)
  );

endmodule

// File: tb/tb_oc8051_pt_loader.sv
// Directed/randomised bench for oc8051_pt_loader with source and page-table bus models.
// Expected writes, cycle counts and abort behaviour come from a simple image/bank model.
module tb_oc8051_pt_loader;
  import oc8051_pt_loader_pkg::*;

  logic        clk, rst, start;
  logic [15:0] img_base;
  logic        busy, done, err;
  logic        src_stb, src_ack;
  logic [15:0] src_addr;
  logic [7:0]  src_data;
  logic        cpu_stb, cpu_wr, cpu_priv, cpu_ack;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        pt_stb, pt_wr, pt_priv, pt_ack;
  logic [15:0] pt_addr;
  logic [7:0]  pt_wdata, pt_rdata;

  oc8051_pt_loader dut (
    .clk(clk), .rst(rst), .start(start), .img_base(img_base),
    .busy(busy), .done(done), .err(err),
    .src_stb(src_stb), .src_addr(src_addr), .src_data(src_data), .src_ack(src_ack),
    .cpu_stb(cpu_stb), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_data(cpu_data),
    .cpu_priv(cpu_priv), .cpu_ack(cpu_ack),
    .pt_stb(pt_stb), .pt_wr(pt_wr), .pt_addr(pt_addr), .pt_wdata(pt_wdata),
    .pt_priv(pt_priv), .pt_rdata(pt_rdata), .pt_ack(pt_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bus models
  logic [7:0]  img [64];
  logic [7:0]  ptmem [64];
  logic [15:0] base_q, block_addr, corrupt_addr;
  logic        src_block, corrupt_en;
  int          src_lat, pt_lat;
  logic [3:0]  src_cnt, pt_cnt;

  assign src_data = img[6'(src_addr - base_q)];
  assign src_ack  = src_stb && (int'(src_cnt) >= src_lat) && !(src_block && src_addr == block_addr);
  assign pt_ack   = pt_stb && (int'(pt_cnt) >= pt_lat);
  assign pt_rdata = (corrupt_en && pt_addr == corrupt_addr) ? 8'h00 : ptmem[pt_addr[5:0]];

  always @(posedge clk) begin
    if (!src_stb || src_ack) src_cnt <= 4'd0;
    else if (src_cnt != 4'hf) src_cnt <= src_cnt + 4'd1;
    if (!pt_stb || pt_ack) pt_cnt <= 4'd0;
    else if (pt_cnt != 4'hf) pt_cnt <= pt_cnt + 4'd1;
  end

  // Monitor: completed page-table writes and event counters
  logic [15:0] wa [$];
  logic [7:0]  wd [$];
  logic        wp [$];
  int done_cnt = 0, busy_cyc = 0, stall_cyc = 0, ack_busy = 0;

  always @(negedge clk) begin
    if (pt_stb && pt_ack && pt_wr) begin
      wa.push_back(pt_addr);
      wd.push_back(pt_wdata);
      wp.push_back(pt_priv);
      ptmem[pt_addr[5:0]] <= pt_wdata;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (busy) busy_cyc <= busy_cyc + 1;
    if (src_stb && src_block && src_addr == block_addr) stall_cyc <= stall_cyc + 1;
    if (busy && cpu_ack) ack_busy <= ack_busy + 1;
  end

  int total = 0, bad = 0;
  int d0, b0, w0, s0, a0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input logic [31:0] obs, input logic [31:0] expv, input string tag);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic snap();
    d0 = done_cnt; b0 = busy_cyc; w0 = wa.size(); s0 = stall_cyc; a0 = ack_busy;
  endtask

  task automatic launch(input logic [15:0] b);
    img_base = b;
    base_q   = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      tick();
      seen = done;
    end
    chk(32'(seen), 1, {tag, "_done_seen"});
  endtask

  // Byte i of the image lands in the write bank for i<32, else in the read bank.
  task automatic check_load(input int base_ix, input int n, input string tag);
    int mism;
    logic [15:0] ea;
    mism = 0;
    chk(wa.size() - base_ix, n, {tag, "_nwr"});
    for (int i = 0; i < n && base_ix + i < wa.size(); i++) begin
      ea = (i < 32) ? PT_WR_BASE + 16'(i) : PT_RD_BASE + 16'(i - 32);
      if (wa[base_ix+i] !== ea || wd[base_ix+i] !== img[i] || wp[base_ix+i] !== 1'b1) mism++;
    end
    chk(mism, 0, {tag, "_wrdata"});
  endtask

  function automatic int exp_cycles(input int sl, input int pl);
    int per;
    per = (sl + 1) + (pl + 1);
`ifdef OC8051_PT_LOADER_VERIFY_EN
    per += pl + 1;
`endif
    return 2 + 64 * per;
  endfunction

  initial begin
    bit got;
    int sl, pl, n88;
    logic [15:0] b;
    rst = 1'b0; start = 1'b0; img_base = 16'h0;
    cpu_stb = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h0; cpu_data = 8'h0; cpu_priv = 1'b0;
    src_lat = 0; pt_lat = 0; src_block = 1'b0; block_addr = 16'h0;
    corrupt_en = 1'b0; corrupt_addr = 16'h0; base_q = 16'h0;
    for (int i = 0; i < 64; i++) img[i] = 8'h00;
    repeat (3) tick();

    // Reset state
    chk(32'(busy), 0, "rst_busy");
    chk(32'(done), 0, "rst_done");
    chk(32'(err), 0, "rst_err");
    chk(32'(src_stb), 0, "rst_src_stb");
    chk(32'(src_addr), 0, "rst_src_addr");
    rst = 1'b1;
    tick();

    // Idle passthrough
    cpu_stb = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'hff85; cpu_data = 8'ha5; cpu_priv = 1'b1;
    #1;
    chk(32'(pt_stb), 1, "pass_stb");
    chk(32'(pt_wr), 1, "pass_wr");
    chk(32'(pt_addr), 32'hff85, "pass_addr");
    chk(32'(pt_wdata), 32'ha5, "pass_wdata");
    chk(32'(pt_priv), 1, "pass_priv");
    chk(32'(cpu_ack), 1, "pass_ack0");
    tick();
    pt_lat = 2; cpu_wr = 1'b0; cpu_addr = 16'hffa3; cpu_priv = 1'b0;
    #1;
    chk(32'(cpu_ack), 0, "pass_ack_wait");
    tick(); tick();
    chk(32'(cpu_ack), 1, "pass_ack_late");
    tick();
    cpu_stb = 1'b0;
    tick();

    // Full zero-wait load, byte i = i ^ 3c
    src_lat = 0; pt_lat = 0;
    for (int i = 0; i < 64; i++) img[i] = 8'(i) ^ 8'h3c;
    snap();
    launch(16'h1000);
    wait_done("zw");
    tick();
    chk(32'(busy), 0, "zw_busy_after");
    chk(32'(err), 0, "zw_err");
    chk(done_cnt - d0, 1, "zw_done_cnt");
    chk(busy_cyc - b0, exp_cycles(0, 0), "zw_cycles");
    check_load(w0, 64, "zw");

    // Start while a CPU write is waiting for pt_ack
    pt_lat = 3; src_lat = 0;
    for (int i = 0; i < 64; i++) img[i] = 8'($urandom);
    snap();
    cpu_stb = 1'b1; cpu_wr = 1'b1; cpu_addr = 16'hff90; cpu_data = 8'h5a; cpu_priv = 1'b0;
    tick();
    launch(16'h3000);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (src_stb) got = 1'b1;
      else tick();
    end
    chk(32'(got), 1, "grant_src_seen");
    chk(wa.size() - w0, 1, "grant_cpu_first");
    if (wa.size() > w0) begin
      chk(32'(wa[w0]), 32'hff90, "grant_cpu_addr");
      chk(32'(wd[w0]), 32'h5a, "grant_cpu_data");
      chk(32'(wp[w0]), 0, "grant_cpu_priv");
    end
    wait_done("grant");
    tick();
    chk(ack_busy - a0, 0, "grant_no_ack_busy");
    check_load(w0 + 1, 64, "grant");
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      got = cpu_ack;
      tick();
    end
    chk(32'(got), 1, "grant_cpu_release");
    cpu_stb = 1'b0;
    tick();

    // CPU stall during a load, plus an ignored start pulse
    pt_lat = 0; src_lat = 1;
    for (int i = 0; i < 64; i++) img[i] = 8'($urandom);
    snap();
    launch(16'($urandom));
    repeat (10) tick();
    cpu_stb = 1'b1; cpu_wr = 1'b0; cpu_addr = 16'hffa7; cpu_priv = 1'b1;
    repeat (20) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("stall");
    tick();
    chk(32'(busy), 0, "stall_busy_after");
    chk(32'(cpu_ack), 1, "stall_first_idle_ack");
    chk(ack_busy - a0, 0, "stall_no_ack_busy");
    chk(done_cnt - d0, 1, "stall_done_cnt");
    chk(busy_cyc - b0, exp_cycles(1, 0), "stall_cycles");
    check_load(w0, 64, "stall");
    tick();
    cpu_stb = 1'b0;
    tick();

    // Source timeout at index 5
    src_lat = 0; pt_lat = 0;
    for (int i = 0; i < 64; i++) img[i] = 8'($urandom);
    b = 16'($urandom);
    block_addr = b + 16'd5;
    src_block = 1'b1;
    snap();
    launch(b);
    wait_done("tmo");
    tick();
    chk(32'(err), 1, "tmo_err");
    chk(32'(busy), 0, "tmo_busy_after");
    chk(done_cnt - d0, 1, "tmo_done_cnt");
    chk(stall_cyc - s0, 255, "tmo_wait_cycles");
    check_load(w0, 5, "tmo");
    src_block = 1'b0;
    tick();

    // Randomised loads: latencies, base (incl. wrap) and image
    for (int k = 0; k < 3; k++) begin
      sl = $urandom_range(0, 3);
      pl = $urandom_range(0, 3);
      src_lat = sl; pt_lat = pl;
      for (int i = 0; i < 64; i++) img[i] = 8'($urandom);
      snap();
      launch((k == 0) ? 16'hffe0 : 16'($urandom));
      wait_done($sformatf("rnd%0d", k));
      tick();
      chk(32'(err), 0, $sformatf("rnd%0d_err", k));
      chk(done_cnt - d0, 1, $sformatf("rnd%0d_done_cnt", k));
      chk(busy_cyc - b0, exp_cycles(sl, pl), $sformatf("rnd%0d_cycles", k));
      check_load(w0, 64, $sformatf("rnd%0d", k));
      tick();
    end

`ifdef OC8051_PT_LOADER_VERIFY_EN
    // Readback of byte 7 returns 00
    src_lat = 0; pt_lat = 0;
    for (int i = 0; i < 64; i++) img[i] = 8'($urandom);
    img[7] = 8'hff;
    corrupt_addr = PT_WR_BASE + 16'd7;
    corrupt_en = 1'b1;
    snap();
    launch(16'h2000);
    wait_done("vfy");
    tick();
    chk(32'(err), 1, "vfy_err");
    chk(done_cnt - d0, 1, "vfy_done_cnt");
    check_load(w0, 8, "vfy");
    n88 = 0;
    for (int i = w0; i < wa.size(); i++) if (wa[i] == 16'hff88) n88++;
    chk(n88, 0, "vfy_no_ff88");
    corrupt_en = 1'b0;
    tick();
`endif

    // Reset in the middle of a load
    src_lat = 0; pt_lat = 0;
    snap();
    launch(16'h4000);
    repeat (25) tick();
    rst = 1'b0;
    #1;
    chk(32'(busy), 0, "mrst_busy");
    chk(32'(src_stb), 0, "mrst_src_stb");
    chk(32'(src_addr), 0, "mrst_src_addr");
    chk(32'(done), 0, "mrst_done");
    chk(32'(pt_stb), 0, "mrst_pt_stb");
    tick();
    rst = 1'b1;
    repeat (5) tick();
    chk(32'(busy), 0, "mrst_stays_idle");
    chk(done_cnt - d0, 0, "mrst_no_done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
